otp_ctrl_ecc_scrub_reg: RTL

ECC-protected register file for buffered OTP partitions, parametrised in word width (32/64) and depth. Replaces per-word concurrent decoders with one read-port decoder plus a sequential background scrubber. The scrubber walks all words on request and reports error status, first-error address and an error count to the partition FSM. An optional mode writes corrected words back.

---
 rtl/otp_ctrl_ecc_scrub_reg.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/otp_ctrl_ecc_scrub_reg.sv
// otp_ctrl_ecc_scrub_reg: SECDED-protected register file with a sequential background scrubber.
// Defining OTP_CTRL_ECC_SCRUB_CORRECT_EN lets the scrubber write corrected words back.
module otp_ctrl_ecc_scrub_reg #(
  parameter int Width = 64,
  parameter int Depth = 128,
  parameter int CntW = 8,
  localparam int EccWidth = (Width == 32) ? 7 : 8,
  localparam int Aw = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wren_i,
  input  logic [Aw-1:0]            addr_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic [1:0]               rerr_o,
  output logic [Depth*Width-1:0]   data_o,
  input  logic                     scrub_req_i,
  output logic                     scrub_busy_o,
  output logic                     scrub_done_o,
  input  logic                     clr_i,
  output logic                     ecc_err_o,
  output logic [Aw-1:0]            err_addr_o,
  output logic [CntW-1:0]          err_cnt_o
);
  if (Width != 32 && Width != 64) begin : g_bad_width
    $fatal(1, "otp_ctrl_ecc_scrub_reg: Width must be 32 or 64");
  end

  function automatic int pop(input int v);
    int c = 0;
    for (int b = 0; b < EccWidth; b++) c += (v >> b) & 1;
    return c;
  endfunction

  // Hsiao columns: all weight-3 patterns first, then weight-5, so every column is odd and distinct.
  function automatic logic [Width*EccWidth-1:0] gen_h();
    logic [Width*EccWidth-1:0] h = '0;
    int n = 0;
    for (int w = 3; w <= 5; w += 2)
      for (int v = 0; v < 2**EccWidth; v++)
        if (pop(v) == w && n < Width) begin
          h[n*EccWidth +: EccWidth] = EccWidth'(v);
          n++;
        end
    return h;
  endfunction

  localparam logic [Width*EccWidth-1:0] HMat = gen_h();
  // Inverted code: the all-zero word is not a valid codeword.
  localparam logic [EccWidth-1:0] InvMask = EccWidth'(8'h5A);
  localparam logic [EccWidth-1:0] ZeroEcc = InvMask;

  function automatic logic [EccWidth-1:0] enc(input logic [Width-1:0] d);
    logic [EccWidth-1:0] e = InvMask;
    for (int i = 0; i < Width; i++) if (d[i]) e ^= HMat[i*EccWidth +: EccWidth];
    return e;
  endfunction

  function automatic logic [1:0] dec_err(input logic [Width-1:0] d, input logic [EccWidth-1:0] e);
    logic [EccWidth-1:0] s = enc(d) ^ e;
    logic hit = $onehot(s);
    for (int i = 0; i < Width; i++) hit |= (s == HMat[i*EccWidth +: EccWidth]);
    return {|s & ~hit, |s & hit};
  endfunction

  function automatic logic [Width-1:0] correct(input logic [Width-1:0] d, input logic [EccWidth-1:0] e);
    logic [EccWidth-1:0] s = enc(d) ^ e;
    logic [Width-1:0] r = d;
    for (int i = 0; i < Width; i++) if (s == HMat[i*EccWidth +: EccWidth]) r[i] = ~d[i];
    return r;
  endfunction

  typedef enum logic [1:0] {
    Idle,
    Check
`ifdef OTP_CTRL_ECC_SCRUB_CORRECT_EN
    , Fix
`endif
  } state_e;

  logic [Width-1:0]    data_q [Depth];
  logic [EccWidth-1:0] ecc_q  [Depth];
  state_e              state_q, state_d;
  logic [Aw-1:0]       ptr_q, ptr_d, err_addr_q, err_addr_d;
  logic [CntW-1:0]     err_cnt_q, err_cnt_d;
  logic                ecc_err_q, ecc_err_d, done_q, done_d;
  logic                addr_ok, last, ev, step, fix_we, we;
  logic [Aw-1:0]       ra, wa;
  logic [Width-1:0]    wd;
  logic [1:0]          sd_err;

  assign addr_ok = int'(addr_i) < Depth;
  assign ra      = addr_ok ? addr_i : '0;
  assign rdata_o = addr_ok ? data_q[ra] : '0;
  assign rerr_o  = addr_ok ? dec_err(data_q[ra], ecc_q[ra]) : 2'b00;
  assign sd_err  = dec_err(data_q[ptr_q], ecc_q[ptr_q]);
  assign last    = ptr_q == Aw'(Depth - 1);

  for (genvar i = 0; i < Depth; i++) begin : g_data
    assign data_o[i*Width +: Width] = data_q[i];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    ev      = 1'b0;
    step    = 1'b0;
    fix_we  = 1'b0;
    if (state_q == Idle) begin
      state_d = scrub_req_i ? Check : Idle;
      ptr_d   = scrub_req_i ? '0 : ptr_q;
    end else if (state_q == Check && !wren_i) begin
      ev = |sd_err;
`ifdef OTP_CTRL_ECC_SCRUB_CORRECT_EN
      state_d = sd_err[0] ? Fix : state_q;
      step    = !sd_err[0];
`else
      step = 1'b1;
`endif
    end
`ifdef OTP_CTRL_ECC_SCRUB_CORRECT_EN
    else if (state_q == Fix && !wren_i) begin
      fix_we = 1'b1;
      step   = 1'b1;
    end
`endif
    if (step) begin
      state_d = last ? Idle : Check;
      ptr_d   = last ? ptr_q : ptr_q + Aw'(1);
      done_d  = last;
    end
  end

  assign ecc_err_d  = clr_i ? ev : (ecc_err_q | ev);
  assign err_cnt_d  = clr_i ? (ev ? CntW'(1) : '0) :
                      ev ? ((&err_cnt_q) ? err_cnt_q : err_cnt_q + CntW'(1)) : err_cnt_q;
  assign err_addr_d = (ev && (clr_i || !ecc_err_q)) ? ptr_q : clr_i ? '0 : err_addr_q;

  // Scrubber write-back only happens while the host is idle, so one write port suffices.
  assign we = (wren_i && addr_ok) || fix_we;
  assign wa = fix_we ? ptr_q : addr_i;
  assign wd = fix_we ? correct(data_q[ptr_q], ecc_q[ptr_q]) : wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        data_q[i] <= '0;
        ecc_q[i]  <= ZeroEcc;
      end
    end else if (we) begin
      data_q[wa] <= wd;
      ecc_q[wa]  <= enc(wd);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      ptr_q      <= '0;
      ecc_err_q  <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ecc_err_q  <= ecc_err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
      done_q     <= done_d;
    end
  end

  assign scrub_busy_o = state_q != Idle;
  assign scrub_done_o = done_q;
  assign ecc_err_o    = ecc_err_q;
  assign err_addr_o   = err_addr_q;
  assign err_cnt_o    = err_cnt_q;
endmodule
